// File: rtl/axis_frame_source.sv
// AXI-Stream producer: packs a free-running sample strobe into fixed-length frames
// with TLAST, buffered by a small first-word-fall-through FIFO that drops on overflow.
module axis_frame_source #(
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             EN,
  input  logic [31:0]      SAMPLE_DATA,
  input  logic             SAMPLE_VALID,
  output logic [31:0]      M_AXIS_TDATA,
  output logic [3:0]       M_AXIS_TKEEP,
  output logic             M_AXIS_TLAST,
  output logic             M_AXIS_TVALID,
  input  logic             M_AXIS_TREADY,
  output logic             OVERFLOW,
  output logic [CNT_W-1:0] DROP_COUNT
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W  = PTR_W + 1;
  localparam int WCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(FIFO_DEPTH);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_LEN - 1);

  logic [32:0]       storage_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [WCNT_W-1:0] wordCnt_q, wordCnt_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  dropCnt_q, dropCnt_d;

  logic full;
  logic pop;
  logic candidate;
  logic push;
  logic drop;
  logic lastWord;

  assign full          = (level_q == DEPTH_L);
  assign M_AXIS_TVALID = (level_q != '0);
  assign pop           = M_AXIS_TVALID & M_AXIS_TREADY;
  // EN only matters between frames; a started frame always runs to completion.
  assign candidate     = SAMPLE_VALID & ~((wordCnt_q == '0) & ~EN);
  assign push          = candidate & (~full | pop);
  assign drop          = candidate & full & ~pop;
  assign lastWord      = (wordCnt_q == LAST_WORD);

  assign {M_AXIS_TLAST, M_AXIS_TDATA} = storage_q[rdPtr_q];
  assign M_AXIS_TKEEP = 4'hF;
  assign OVERFLOW     = overflow_q;
  assign DROP_COUNT   = dropCnt_q;

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    level_d    = level_q;
    wordCnt_d  = wordCnt_q;
    overflow_d = overflow_q;
    dropCnt_d  = dropCnt_q;

    if (push) begin
      wrPtr_d   = wrPtr_q + 1'b1;
      wordCnt_d = lastWord ? '0 : wordCnt_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // A dropped sample leaves the word counter alone so frames keep their length.
    if (drop) begin
      overflow_d = 1'b1;
      if (dropCnt_q != '1) begin
        dropCnt_d = dropCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      wordCnt_q  <= '0;
      overflow_q <= 1'b0;
      dropCnt_q  <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      wordCnt_q  <= wordCnt_d;
      overflow_q <= overflow_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) begin
      storage_q[wrPtr_q] <= {lastWord, SAMPLE_DATA};
    end
  end

endmodule

// File: tb/tb_axis_frame_source.sv
// Self-checking bench for axis_frame_source: a queue-based reference model checked every
// cycle, plus literal frame-content expectations per directed scenario.
module tb_axis_frame_source;

  localparam int FRAME_LEN  = 4;
  localparam int FIFO_DEPTH = 16;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        EN;
  logic [31:0] SAMPLE_DATA;
  logic        SAMPLE_VALID;
  logic        M_AXIS_TREADY;

  logic [31:0] tdata16, tdata2;
  logic [3:0]  tkeep16, tkeep2;
  logic        tlast16, tlast2;
  logic        tvalid16, tvalid2;
  logic        ovf16, ovf2;
  logic [15:0] drop16;
  logic [1:0]  drop2;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  beat_t mq[$];
  int    mWcnt;
  int    mDrops;
  bit    mOvf;
  bit    mPop;
  bit    mCand;

  beat_t logBeats[$];
  beat_t expBeats[$];

  always #5 ACLK = ~ACLK;

  axis_frame_source #(.FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(16)) dut16 (
    .ACLK(ACLK), .ARESET(ARESET), .EN(EN), .SAMPLE_DATA(SAMPLE_DATA),
    .SAMPLE_VALID(SAMPLE_VALID), .M_AXIS_TDATA(tdata16), .M_AXIS_TKEEP(tkeep16),
    .M_AXIS_TLAST(tlast16), .M_AXIS_TVALID(tvalid16), .M_AXIS_TREADY(M_AXIS_TREADY),
    .OVERFLOW(ovf16), .DROP_COUNT(drop16)
  );

  axis_frame_source #(.FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(2)) dut2 (
    .ACLK(ACLK), .ARESET(ARESET), .EN(EN), .SAMPLE_DATA(SAMPLE_DATA),
    .SAMPLE_VALID(SAMPLE_VALID), .M_AXIS_TDATA(tdata2), .M_AXIS_TKEEP(tkeep2),
    .M_AXIS_TLAST(tlast2), .M_AXIS_TVALID(tvalid2), .M_AXIS_TREADY(M_AXIS_TREADY),
    .OVERFLOW(ovf2), .DROP_COUNT(drop2)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: the FIFO is a queue, frames are counted modulo FRAME_LEN.
  always @(posedge ACLK) begin
    if (ARESET) begin
      mq.delete();
      mWcnt  = 0;
      mDrops = 0;
      mOvf   = 1'b0;
    end else begin
      mPop  = (mq.size() != 0) && M_AXIS_TREADY;
      mCand = SAMPLE_VALID && !(mWcnt == 0 && !EN);
      if (mPop) void'(mq.pop_front());
      if (mCand) begin
        if (mq.size() < FIFO_DEPTH) begin
          mq.push_back(beat_t'({mWcnt == FRAME_LEN - 1, SAMPLE_DATA}));
          mWcnt = (mWcnt + 1) % FRAME_LEN;
        end else begin
          mOvf = 1'b1;
          mDrops++;
        end
      end
    end
  end

  // Compare both instances with the model on every cycle, and log accepted beats.
  always @(negedge ACLK) begin
    if (checkEn) begin
      checkOutput("tvalid16", 64'(tvalid16), 64'(mq.size() != 0));
      checkOutput("tvalid2", 64'(tvalid2), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        checkOutput("tdata16", 64'(tdata16), 64'(mq[0].data));
        checkOutput("tlast16", 64'(tlast16), 64'(mq[0].last));
        checkOutput("tdata2", 64'(tdata2), 64'(mq[0].data));
        checkOutput("tlast2", 64'(tlast2), 64'(mq[0].last));
      end
      checkOutput("tkeep16", 64'(tkeep16), 64'h F);
      checkOutput("tkeep2", 64'(tkeep2), 64'h F);
      checkOutput("overflow16", 64'(ovf16), 64'(mOvf));
      checkOutput("overflow2", 64'(ovf2), 64'(mOvf));
      checkOutput("dropcount16", 64'(drop16), 64'((mDrops > 65535) ? 65535 : mDrops));
      checkOutput("dropcount2", 64'(drop2), 64'((mDrops > 3) ? 3 : mDrops));
      if (!ARESET && tvalid16 && M_AXIS_TREADY) begin
        logBeats.push_back(beat_t'({tlast16, tdata16}));
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic en,
                               input logic rdy);
    @(posedge ACLK);
    #2;
    SAMPLE_VALID  = v;
    SAMPLE_DATA   = d;
    EN            = en;
    M_AXIS_TREADY = rdy;
  endtask

  task automatic idle(input int n, input logic en, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, en, rdy);
  endtask

  task automatic pulseReset();
    @(posedge ACLK);
    #2;
    ARESET       = 1'b1;
    SAMPLE_VALID = 1'b0;
    @(posedge ACLK);
    #2;
    ARESET = 1'b0;
  endtask

  // Frames here start at 'base', so every 4th word from it carries TLAST.
  task automatic expectRange(input int lo, input int hi, input int base);
    beat_t b;
    expBeats.delete();
    for (int i = lo; i <= hi; i++) begin
      b.last = (((i - base) % FRAME_LEN) == FRAME_LEN - 1);
      b.data = 32'(i);
      expBeats.push_back(b);
    end
  endtask

  task automatic checkBeats(input string name);
    checkOutput({name, "_count"}, 64'(logBeats.size()), 64'(expBeats.size()));
    for (int i = 0; i < logBeats.size() && i < expBeats.size(); i++) begin
      checkOutput(name, 64'(logBeats[i]), 64'(expBeats[i]));
    end
    logBeats.delete();
  endtask

  initial begin
    ARESET        = 1'b1;
    EN            = 1'b0;
    SAMPLE_VALID  = 1'b0;
    SAMPLE_DATA   = 32'h0;
    M_AXIS_TREADY = 1'b0;
    @(posedge ACLK);
    #1 checkEn = 1'b1;
    @(posedge ACLK);
    #2 ARESET = 1'b0;
    checkOutput("reset_tvalid", 64'(tvalid16), 64'h0);
    checkOutput("reset_overflow", 64'(ovf16), 64'h0);
    checkOutput("reset_drop", 64'(drop16), 64'h0);

    $display("[TB] back-to-back frames");
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 32'(i), 1'b1, 1'b1);
    idle(4, 1'b1, 1'b1);
    expectRange(1, 8, 1);
    checkBeats("t1_beats");
    checkOutput("t1_drop", 64'(drop16), 64'h0);

    $display("[TB] overflow with stalled sink");
    for (int i = 101; i <= 120; i++) applyStimulus(1'b1, 32'(i), 1'b1, 1'b0);
    idle(1, 1'b1, 1'b0);
    checkOutput("t2_drop16", 64'(drop16), 64'd4);
    checkOutput("t2_drop2", 64'(drop2), 64'd3);
    checkOutput("t2_overflow", 64'(ovf16), 64'h1);
    checkOutput("t2_head", 64'(tdata16), 64'd101);
    idle(20, 1'b1, 1'b1);
    expectRange(101, 116, 101);
    checkBeats("t2_beats");

    $display("[TB] push and pop while full");
    for (int i = 201; i <= 216; i++) applyStimulus(1'b1, 32'(i), 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd217, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'd999, 1'b1, 1'b0);
    checkOutput("t3_drop_after_pushpop", 64'(drop16), 64'd4);
    idle(1, 1'b1, 1'b0);
    checkOutput("t3_drop_still_full", 64'(drop16), 64'd5);
    for (int i = 218; i <= 220; i++) applyStimulus(1'b1, 32'(i), 1'b1, 1'b1);
    idle(24, 1'b1, 1'b1);
    expectRange(201, 220, 201);
    checkBeats("t3_beats");

    $display("[TB] enable dropped mid-frame");
    applyStimulus(1'b1, 32'd301, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'd302, 1'b1, 1'b1);
    for (int i = 303; i <= 307; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b1);
    idle(4, 1'b0, 1'b1);
    expectRange(301, 304, 301);
    checkBeats("t4_beats");
    checkOutput("t4_drop", 64'(drop16), 64'd5);

    $display("[TB] disabled source");
    for (int i = 401; i <= 410; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b1);
    idle(3, 1'b0, 1'b1);
    checkOutput("t5_beats_count", 64'(logBeats.size()), 64'h0);
    checkOutput("t5_tvalid", 64'(tvalid16), 64'h0);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 32'd501, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd502, 1'b1, 1'b0);
    pulseReset();
    checkOutput("t6_tvalid", 64'(tvalid16), 64'h0);
    checkOutput("t6_drop", 64'(drop16), 64'h0);
    checkOutput("t6_overflow", 64'(ovf16), 64'h0);
    logBeats.delete();
    for (int i = 9; i <= 12; i++) applyStimulus(1'b1, 32'(i), 1'b1, 1'b1);
    idle(4, 1'b1, 1'b1);
    expectRange(9, 12, 9);
    checkBeats("t6_beats");

    $display("[TB] drop counter saturation");
    for (int i = 601; i <= 622; i++) applyStimulus(1'b1, 32'(i), 1'b1, 1'b0);
    idle(1, 1'b1, 1'b0);
    checkOutput("t7_drop2", 64'(drop2), 64'd3);
    checkOutput("t7_drop16", 64'(drop16), 64'd6);
    checkOutput("t7_overflow2", 64'(ovf2), 64'h1);
    idle(20, 1'b1, 1'b1);
    expectRange(601, 616, 601);
    checkBeats("t7_beats");

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
